// File: rtl/multicycle_controller_if.sv
// Control/status bundle between the FRiscV multicycle controller and its datapath.
// The controller holds the master view; the datapath (or a bench standing in for it) holds the slave view.
interface multicycle_controller_if;
  logic [6:0] op_code_in;
  logic [2:0] func3_in;
  logic [6:0] func7_in;
  logic       zero_in;
  logic       mem_ready_in;

  logic       mem_req_out;
  logic       mem_write_out;
  logic       adr_src_out;
  logic       ir_write_out;
  logic       pc_write_out;
  logic       reg_write_out;
  logic [1:0] alu_src_a_out;
  logic [1:0] alu_src_b_out;
  logic [3:0] alu_ctrl_out;
  logic [1:0] result_src_out;
  logic       illegal_instr_out;

  modport master (
    input  op_code_in, func3_in, func7_in, zero_in, mem_ready_in,
    output mem_req_out, mem_write_out, adr_src_out, ir_write_out, pc_write_out,
           reg_write_out, alu_src_a_out, alu_src_b_out, alu_ctrl_out,
           result_src_out, illegal_instr_out
  );

  modport slave (
    output op_code_in, func3_in, func7_in, zero_in, mem_ready_in,
    input  mem_req_out, mem_write_out, adr_src_out, ir_write_out, pc_write_out,
           reg_write_out, alu_src_a_out, alu_src_b_out, alu_ctrl_out,
           result_src_out, illegal_instr_out
  );
endinterface

// File: rtl/multicycle_controller.sv
// FRiscV shared encodings plus the multicycle controller that sequences
// fetch/decode/execute/memory/writeback over one shared instruction/data memory.
package friscv_pkg;
  localparam logic [6:0] REG       = 7'b0110011;
  localparam logic [6:0] IMM_ARITH = 7'b0010011;
  localparam logic [6:0] IMM_LOAD  = 7'b0000011;
  localparam logic [6:0] STORE     = 7'b0100011;
  localparam logic [6:0] BRANCH    = 7'b1100011;
  localparam logic [6:0] JUMP      = 7'b1101111;

  localparam logic [3:0] ADD = 4'b0010;
  localparam logic [3:0] SUB = 4'b0110;

  localparam logic       ADR_PC     = 1'b0;
  localparam logic       ADR_ALUOUT = 1'b1;
  localparam logic [1:0] A_PC       = 2'b00;
  localparam logic [1:0] A_OLD_PC   = 2'b01;
  localparam logic [1:0] A_RS1      = 2'b10;
  localparam logic [1:0] B_RS2      = 2'b00;
  localparam logic [1:0] B_IMM      = 2'b01;
  localparam logic [1:0] B_FOUR     = 2'b10;
  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_MEM    = 2'b01;
  localparam logic [1:0] RES_ALU    = 2'b10;

  typedef struct packed {
    logic       mem_req;
    logic       mem_write;
    logic       adr_src;
    logic       ir_write;
    logic       pc_write;
    logic       reg_write;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [3:0] alu_ctrl;
    logic [1:0] result_src;
    logic       illegal_instr;
  } ctrl_t;
endpackage

module multicycle_controller
  import friscv_pkg::*;
(
  input logic                     clk_in,
  input logic                     rstn_in,
  multicycle_controller_if.master bus
);

  typedef enum logic [3:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_MEM_ADDR,
    S_MEM_READ,
    S_MEM_WB,
    S_MEM_WRITE,
    S_EXEC_R,
    S_EXEC_I,
    S_ALU_WB,
    S_BEQ,
    S_JAL,
    S_TRAP
  } state_e;

  state_e state_q, state_d;
  ctrl_t  ctrl;

  logic f3_zero;
  assign f3_zero = (bus.func3_in == 3'd0);

  always_comb begin
    // NOTE: a default on entry keeps every path assigned, so no latch is inferred.
    state_d = state_q;
    case (state_q)
      S_IDLE:      state_d = S_FETCH;
      S_FETCH:     if (bus.mem_ready_in) state_d = S_DECODE;
      S_DECODE: begin
        case (bus.op_code_in)
          IMM_LOAD, STORE: state_d = S_MEM_ADDR;
          REG:             state_d = S_EXEC_R;
          IMM_ARITH:       state_d = S_EXEC_I;
          BRANCH:          state_d = S_BEQ;
          JUMP:            state_d = S_JAL;
          default:         state_d = S_TRAP;
        endcase
      end
      S_MEM_ADDR: begin
        if (bus.func3_in != 3'd2)            state_d = S_TRAP;
        else if (bus.op_code_in == IMM_LOAD) state_d = S_MEM_READ;
        else                                 state_d = S_MEM_WRITE;
      end
      S_MEM_READ:  if (bus.mem_ready_in) state_d = S_MEM_WB;
      S_MEM_WB:    state_d = S_FETCH;
      S_MEM_WRITE: if (bus.mem_ready_in) state_d = S_FETCH;
      S_EXEC_R:    state_d = f3_zero ? S_ALU_WB : S_TRAP;
      S_EXEC_I:    state_d = f3_zero ? S_ALU_WB : S_TRAP;
      S_ALU_WB:    state_d = S_FETCH;
      S_BEQ:       state_d = f3_zero ? S_FETCH : S_TRAP;
      S_JAL:       state_d = S_ALU_WB;
      S_TRAP:      state_d = S_TRAP;
      default:     state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk_in or negedge rstn_in) begin
    if (!rstn_in) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  // Control outputs are decoded from the registered state so they drop with reset at once.
  always_comb begin
    ctrl = '0;
    case (state_q)
      S_FETCH: begin
        ctrl.mem_req    = 1'b1;
        ctrl.adr_src    = ADR_PC;
        ctrl.alu_src_a  = A_PC;
        ctrl.alu_src_b  = B_FOUR;
        ctrl.alu_ctrl   = ADD;
        ctrl.result_src = RES_ALU;
        ctrl.ir_write   = bus.mem_ready_in;
        ctrl.pc_write   = bus.mem_ready_in;
      end
      S_DECODE: begin
        ctrl.alu_src_a = A_OLD_PC;
        ctrl.alu_src_b = B_IMM;
        ctrl.alu_ctrl  = ADD;
      end
      S_MEM_ADDR, S_EXEC_I: begin
        ctrl.alu_src_a = A_RS1;
        ctrl.alu_src_b = B_IMM;
        ctrl.alu_ctrl  = ADD;
      end
      S_MEM_READ: begin
        ctrl.mem_req = 1'b1;
        ctrl.adr_src = ADR_ALUOUT;
      end
      S_MEM_WRITE: begin
        ctrl.mem_req   = 1'b1;
        ctrl.mem_write = 1'b1;
        ctrl.adr_src   = ADR_ALUOUT;
      end
      S_MEM_WB: begin
        ctrl.result_src = RES_MEM;
        ctrl.reg_write  = 1'b1;
      end
      S_EXEC_R: begin
        ctrl.alu_src_a = A_RS1;
        ctrl.alu_src_b = B_RS2;
        ctrl.alu_ctrl  = (bus.func7_in == 7'd0) ? ADD : SUB;
      end
      S_ALU_WB: begin
        ctrl.result_src = RES_ALUOUT;
        ctrl.reg_write  = 1'b1;
      end
      S_BEQ: begin
        ctrl.alu_src_a  = A_RS1;
        ctrl.alu_src_b  = B_RS2;
        ctrl.alu_ctrl   = SUB;
        ctrl.result_src = RES_ALUOUT;
        // A malformed branch heads to TRAP and must not redirect the PC on the way.
        ctrl.pc_write   = bus.zero_in & f3_zero;
      end
      S_JAL: begin
        ctrl.alu_src_a  = A_OLD_PC;
        ctrl.alu_src_b  = B_FOUR;
        ctrl.alu_ctrl   = ADD;
        ctrl.result_src = RES_ALUOUT;
        ctrl.pc_write   = 1'b1;
      end
      S_TRAP:  ctrl.illegal_instr = 1'b1;
      default: ctrl = '0;
    endcase
  end

  assign bus.mem_req_out       = ctrl.mem_req;
  assign bus.mem_write_out     = ctrl.mem_write;
  assign bus.adr_src_out       = ctrl.adr_src;
  assign bus.ir_write_out      = ctrl.ir_write;
  assign bus.pc_write_out      = ctrl.pc_write;
  assign bus.reg_write_out     = ctrl.reg_write;
  assign bus.alu_src_a_out     = ctrl.alu_src_a;
  assign bus.alu_src_b_out     = ctrl.alu_src_b;
  assign bus.alu_ctrl_out      = ctrl.alu_ctrl;
  assign bus.result_src_out    = ctrl.result_src;
  assign bus.illegal_instr_out = ctrl.illegal_instr;

endmodule

// File: tb/tb_multicycle_controller.sv
// Scoreboard bench: an instruction-level model pushes the expected control word for
// every cycle; a negedge monitor pops and compares it against the controller outputs.
module tb_multicycle_controller;
  import friscv_pkg::*;

  typedef struct packed {
    logic       mem_req;
    logic       mem_write;
    logic       adr_src;
    logic       ir_write;
    logic       pc_write;
    logic       reg_write;
    logic [1:0] a;
    logic [1:0] b;
    logic [3:0] alu;
    logic [1:0] res;
    logic       illegal;
  } ctl_t;

  typedef struct {
    ctl_t  ctl;
    string tag;
  } exp_t;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  multicycle_controller_if bus ();

  multicycle_controller dut (
    .clk_in  (clk),
    .rstn_in (rstn),
    .bus     (bus)
  );

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  logic [6:0] cur_op;
  logic [2:0] cur_f3;
  logic [6:0] cur_f7;

  task automatic check(input string name, input ctl_t act, input ctl_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @%0t: got req=%b wr=%b adr=%b irw=%b pcw=%b rw=%b a=%b b=%b alu=%h res=%b ill=%b, expected req=%b wr=%b adr=%b irw=%b pcw=%b rw=%b a=%b b=%b alu=%h res=%b ill=%b",
               name, $time,
               act.mem_req, act.mem_write, act.adr_src, act.ir_write, act.pc_write, act.reg_write,
               act.a, act.b, act.alu, act.res, act.illegal,
               exp.mem_req, exp.mem_write, exp.adr_src, exp.ir_write, exp.pc_write, exp.reg_write,
               exp.a, exp.b, exp.alu, exp.res, exp.illegal);
    end
  endtask

  function automatic ctl_t sample();
    ctl_t s;
    s.mem_req   = bus.mem_req_out;
    s.mem_write = bus.mem_write_out;
    s.adr_src   = bus.adr_src_out;
    s.ir_write  = bus.ir_write_out;
    s.pc_write  = bus.pc_write_out;
    s.reg_write = bus.reg_write_out;
    s.a         = bus.alu_src_a_out;
    s.b         = bus.alu_src_b_out;
    s.alu       = bus.alu_ctrl_out;
    s.res       = bus.result_src_out;
    s.illegal   = bus.illegal_instr_out;
    return s;
  endfunction

  // Monitor: every cycle with a pending expectation is compared mid-cycle.
  exp_t mon_e;
  always @(negedge clk) begin
    if (sb_q.size() > 0) begin
      mon_e = sb_q.pop_front();
      check(mon_e.tag, sample(), mon_e.ctl);
    end
  end

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  // Drive one cycle of inputs and record what the controller must show in it.
  task automatic step(input string tag, input ctl_t e, input logic ready, input logic zero,
                      input bit ir_valid);
    exp_t x;
    bus.mem_ready_in = ready;
    bus.zero_in      = zero;
    if (ir_valid) begin
      bus.op_code_in = cur_op;
      bus.func3_in   = cur_f3;
      bus.func7_in   = cur_f7;
    end else begin
      bus.op_code_in = 7'($urandom);
      bus.func3_in   = 3'($urandom);
      bus.func7_in   = 7'($urandom);
    end
    x.ctl = e;
    x.tag = tag;
    sb_q.push_back(x);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int n);
    rstn = 1'b0;
    repeat (n) step("reset", '0, rb(), rb(), 1'b0);
    rstn = 1'b1;
    step("idle", '0, rb(), rb(), 1'b0);
  endtask

  task automatic fetch(input int waits);
    ctl_t e = '0;
    e.mem_req = 1'b1;
    e.b       = 2'b10;
    e.alu     = ADD;
    e.res     = 2'b10;
    repeat (waits) step("fetch_wait", e, 1'b0, rb(), 1'b0);
    e.ir_write = 1'b1;
    e.pc_write = 1'b1;
    step("fetch_ready", e, 1'b1, rb(), 1'b0);
  endtask

  task automatic mem_access(input bit wr, input int waits);
    ctl_t e = '0;
    e.mem_req   = 1'b1;
    e.mem_write = wr;
    e.adr_src   = 1'b1;
    repeat (waits) step(wr ? "store_wait" : "load_wait", e, 1'b0, rb(), 1'b1);
    step(wr ? "store_ready" : "load_ready", e, 1'b1, rb(), 1'b1);
  endtask

  task automatic alu_wb();
    ctl_t e = '0;
    e.reg_write = 1'b1;
    step("alu_wb", e, rb(), rb(), 1'b1);
  endtask

  task automatic trap_cycles(input int n);
    ctl_t e = '0;
    e.illegal = 1'b1;
    repeat (n) step("trap", e, rb(), rb(), 1'b1);
  endtask

  // Instruction-level reference: the cycle-by-cycle control words an instruction must produce.
  task automatic run_instr(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                           input logic z, input int fw, input int dw, output bit trapped);
    ctl_t e;
    trapped = 1'b0;
    cur_op  = op;
    cur_f3  = f3;
    cur_f7  = f7;
    fetch(fw);
    e = '0; e.a = 2'b01; e.b = 2'b01; e.alu = ADD;
    step("decode", e, rb(), rb(), 1'b1);
    if (op == IMM_LOAD || op == STORE) begin
      e = '0; e.a = 2'b10; e.b = 2'b01; e.alu = ADD;
      step("mem_addr", e, rb(), rb(), 1'b1);
      if (f3 != 3'd2) begin
        trapped = 1'b1;
        return;
      end
      mem_access(op == STORE, dw);
      if (op == IMM_LOAD) begin
        e = '0; e.res = 2'b01; e.reg_write = 1'b1;
        step("mem_wb", e, rb(), rb(), 1'b1);
      end
    end else if (op == REG) begin
      e = '0; e.a = 2'b10; e.b = 2'b00; e.alu = (f7 == 7'd0) ? ADD : SUB;
      step("exec_r", e, rb(), rb(), 1'b1);
      if (f3 != 3'd0) trapped = 1'b1;
      else alu_wb();
    end else if (op == IMM_ARITH) begin
      e = '0; e.a = 2'b10; e.b = 2'b01; e.alu = ADD;
      step("exec_i", e, rb(), rb(), 1'b1);
      if (f3 != 3'd0) trapped = 1'b1;
      else alu_wb();
    end else if (op == BRANCH) begin
      e = '0; e.a = 2'b10; e.b = 2'b00; e.alu = SUB;
      e.pc_write = (f3 == 3'd0) && z;
      step("beq", e, rb(), z, 1'b1);
      if (f3 != 3'd0) trapped = 1'b1;
    end else if (op == JUMP) begin
      e = '0; e.a = 2'b01; e.b = 2'b10; e.alu = ADD; e.pc_write = 1'b1;
      step("jal", e, rb(), rb(), 1'b1);
      alu_wb();
    end else begin
      trapped = 1'b1;
    end
  endtask

  task automatic rand_legal();
    bit         t;
    logic [6:0] op;
    logic [2:0] f3;
    logic [6:0] f7;
    case ($urandom_range(0, 5))
      0:       begin op = REG;       f3 = 3'd0; end
      1:       begin op = IMM_ARITH; f3 = 3'd0; end
      2:       begin op = IMM_LOAD;  f3 = 3'd2; end
      3:       begin op = STORE;     f3 = 3'd2; end
      4:       begin op = BRANCH;    f3 = 3'd0; end
      default: begin op = JUMP;      f3 = 3'($urandom); end
    endcase
    f7 = ($urandom_range(0, 2) == 0) ? 7'd0 : 7'($urandom);
    run_instr(op, f3, f7, rb(), $urandom_range(0, 2), $urandom_range(0, 2), t);
    if (t) begin
      checks++;
      errors++;
      $display("FAIL rand_model: legal instruction op=%h f3=%0d classified as trap", op, f3);
    end
  endtask

  task automatic expect_trap(input logic [6:0] op, input logic [2:0] f3, input logic z);
    bit t;
    run_instr(op, f3, 7'd0, z, 0, 0, t);
    if (t) trap_cycles(20);
    do_reset(2);
  endtask

  initial begin
    bit t;
    bus.op_code_in   = '0;
    bus.func3_in     = '0;
    bus.func7_in     = '0;
    bus.zero_in      = 1'b0;
    bus.mem_ready_in = 1'b0;
    @(posedge clk);
    #1;
    do_reset(3);

    run_instr(REG,       3'd0, 7'h00, 1'b0, 0, 0, t);
    run_instr(REG,       3'd0, 7'h20, 1'b0, 0, 0, t);
    run_instr(IMM_LOAD,  3'd2, 7'h00, 1'b0, 0, 2, t);
    run_instr(BRANCH,    3'd0, 7'h00, 1'b1, 0, 0, t);
    run_instr(BRANCH,    3'd0, 7'h00, 1'b0, 0, 0, t);
    run_instr(JUMP,      3'd5, 7'h00, 1'b0, 0, 0, t);
    run_instr(STORE,     3'd2, 7'h00, 1'b0, 1, 1, t);
    run_instr(IMM_ARITH, 3'd0, 7'h7f, 1'b0, 2, 0, t);

    for (int i = 0; i < 40; i++) rand_legal();

    // Reset asserted mid-fetch must drop every output before the next edge.
    cur_op = REG; cur_f3 = 3'd0; cur_f7 = 7'd0;
    begin
      ctl_t e = '0;
      e.mem_req = 1'b1; e.b = 2'b10; e.alu = ADD; e.res = 2'b10;
      step("fetch_wait", e, 1'b0, rb(), 1'b0);
    end
    do_reset(1);

    expect_trap(7'h73,     3'd0, 1'b0);
    expect_trap(IMM_LOAD,  3'd0, 1'b0);
    expect_trap(BRANCH,    3'd1, 1'b1);
    expect_trap(REG,       3'd1, 1'b0);
    expect_trap(IMM_ARITH, 3'd3, 1'b0);
    expect_trap(STORE,     3'd1, 1'b0);

    run_instr(IMM_LOAD, 3'd2, 7'h00, 1'b0, 1, 0, t);

    @(negedge clk);
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d expectations left, expected 0", sb_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
